// File: rtl/aes_pkg.sv
// Shared types and constants for the AES data path.
//   BYTE_W/BLOCK_BYTES/BLOCK_W : byte and block geometry
//   CNT_W                      : width of a 0..BLOCK_BYTES byte counter
//   block_t/byte_t/cnt_t       : convenience vector types
//   deser_state_t              : deserializer FSM states
package aes_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = BYTE_W * BLOCK_BYTES;
    localparam int unsigned CNT_W       = 5;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [BYTE_W-1:0]  byte_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } deser_state_t;

endpackage : aes_pkg

// File: rtl/atd_deserializer_if.sv
// Byte-in / block-out bundle of the ATD deserializer.
//   master : byte source + control unit (drives byte_in, byte_valid, clear, atd_take)
//   slave  : deserializer (drives byte_ready, ATD_parallel, atd_full, byte_count, take_err)
interface atd_deserializer_if;
    import aes_pkg::*;

    byte_t  byte_in;
    logic   byte_valid;
    logic   byte_ready;
    logic   clear;
    logic   atd_take;
    block_t ATD_parallel;
    logic   atd_full;
    cnt_t   byte_count;
    logic   take_err;

    modport master (
        output byte_in, byte_valid, clear, atd_take,
        input  byte_ready, ATD_parallel, atd_full, byte_count, take_err
    );

    modport slave (
        input  byte_in, byte_valid, clear, atd_take,
        output byte_ready, ATD_parallel, atd_full, byte_count, take_err
    );

endinterface : atd_deserializer_if

// File: rtl/byte_shift_reg.sv
// Left-shifting register that appends SHIFT_W bits at the LSB end per enable.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : synchronous clear to zero (wins over en_i)
//   en_i     : shift din_i in this cycle
//   din_i    : incoming SHIFT_W-bit chunk
//   q_o      : register contents; oldest chunk sits in the MSBs
module byte_shift_reg #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned SHIFT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [SHIFT_W-1:0] din_i,
    output logic [WIDTH-1:0]   q_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Next value: clear, shift-in, or hold
    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {shift_q[WIDTH-SHIFT_W-1:0], din_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q_o = shift_q;

endmodule : byte_shift_reg

// File: rtl/atd_deserializer.sv
// Packs BLOCK_BYTES handshaked bytes into one block for the data-register mux
// and holds it until the control unit takes it.
//   clk, rst     : clock and synchronous active-high reset
//   bus.slave    : byte_in/byte_valid/byte_ready byte handshake,
//                  clear (abort), atd_take (block consumed),
//                  ATD_parallel/atd_full (block out), byte_count, take_err (sticky)
module atd_deserializer
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    atd_deserializer_if.slave  bus
);

    deser_state_t state_q, state_d;
    cnt_t         count_q, count_d;
    logic         full_q,  full_d;
    logic         err_q,   err_d;

    logic         byte_ready_c;
    logic         accept_c;
    block_t       block_w;

    // Ready depends only on state and clear, never on byte_valid
    assign byte_ready_c = (state_q == FILL) && !bus.clear;
    assign accept_c     = bus.byte_valid && byte_ready_c;

    byte_shift_reg #(
        .WIDTH   (BLOCK_W),
        .SHIFT_W (BYTE_W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clear),
        .en_i  (accept_c),
        .din_i (bus.byte_in),
        .q_o   (block_w)
    );

    // Next-state logic: clear beats take and accept
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;

        if (bus.clear) begin
            state_d = FILL;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (bus.atd_take) begin
                        err_d = 1'b1;
                    end
                    if (accept_c) begin
                        count_d = count_q + cnt_t'(1);
                        if (count_q == cnt_t'(BLOCK_BYTES - 1)) begin
                            state_d = FULL;
                            full_d  = 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Block contents stay in place; only the bookkeeping restarts
                    if (bus.atd_take) begin
                        state_d = FILL;
                        count_d = '0;
                        full_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready   = byte_ready_c;
    assign bus.ATD_parallel = block_w;
    assign bus.atd_full     = full_q;
    assign bus.byte_count   = count_q;
    assign bus.take_err     = err_q;

endmodule : atd_deserializer
